// File: rtl/fpg8_pkg.sv
// Shared FPG8 encodings: opcodes, ALU controls, GPR selects, sequencer states
// and the strobe bundle produced by the control decoder.
package fpg8_pkg;

    typedef enum logic [3:0] {
        OpNop  = 4'd0,
        OpAdd  = 4'd1,
        OpSub  = 4'd2,
        OpAnd  = 4'd3,
        OpOr   = 4'd4,
        OpXor  = 4'd5,
        OpNot  = 4'd6,
        OpMov  = 4'd7,
        OpLd   = 4'd8,
        OpSt   = 4'd9,
        OpHalt = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        AluAdd  = 3'd0,
        AluSub  = 3'd1,
        AluAnd  = 3'd2,
        AluOr   = 3'd3,
        AluXor  = 3'd4,
        AluNot  = 3'd5,
        AluPass = 3'd6,
        AluInc  = 3'd7
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        SelRd1 = 3'd0,
        SelRd2 = 3'd1,
        SelRs1 = 3'd2,
        SelRs2 = 3'd3,
        SelPc  = 3'd4
    } gpr_sel_e;

    typedef enum logic [3:0] {
        StF0  = 4'd0,
        StF1  = 4'd1,
        StF2  = 4'd2,
        StDec = 4'd3,
        StE0  = 4'd4,
        StE1  = 4'd5,
        StE2  = 4'd6,
        StM0  = 4'd7,
        StM1  = 4'd8,
        StM2  = 4'd9,
        StHlt = 4'd10
    } state_e;

    typedef struct packed {
        alu_ctrl_e alu_control;
        gpr_sel_e  gpr_select;
        logic      gpr_in;
        logic      gpr_out;
        logic      ir_in;
        logic      mar_in;
        logic      mdr_in;
        logic      mdr_out;
        logic      ram_read;
        logic      ram_write;
        logic      y_in;
        logic      y_offset_in;
        logic      z_in;
        logic      z_out;
    } strobes_t;

    // Two-operand ALU instructions: ADD..XOR.
    function automatic logic is_alu2(input logic [3:0] op);
        return (op >= OpAdd) && (op <= OpXor);
    endfunction

    // Single-operand instructions that skip the Y load.
    function automatic logic is_unary(input logic [3:0] op);
        return (op == OpNot) || (op == OpMov);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OpLd) || (op == OpSt);
    endfunction

    function automatic alu_ctrl_e op_to_alu(input logic [3:0] op);
        case (op)
            OpSub:   return AluSub;
            OpAnd:   return AluAnd;
            OpOr:    return AluOr;
            OpXor:   return AluXor;
            OpNot:   return AluNot;
            OpMov:   return AluPass;
            default: return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the FPG8 datapath (slave).
interface control_sequencer_if;

    logic       run;
    logic [3:0] opcode;
    logic       S;

    logic [2:0] ALU_control;
    logic       GPR_in;
    logic       GPR_out;
    logic [2:0] GPR_select;
    logic       IR_in;
    logic       MAR_in;
    logic       MDR_in;
    logic       MDR_out;
    logic       RAM_enable_read;
    logic       RAM_enable_write;
    logic       Y_in;
    logic       Y_out;
    logic       Y_offset_in;
    logic       Z_in;
    logic       Z_out;

    logic       halted;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  run, opcode, S,
        output ALU_control, GPR_in, GPR_out, GPR_select, IR_in, MAR_in, MDR_in, MDR_out,
               RAM_enable_read, RAM_enable_write, Y_in, Y_out, Y_offset_in, Z_in, Z_out,
               halted, illegal_op, state
    );

    modport slave (
        output run, opcode, S,
        input  ALU_control, GPR_in, GPR_out, GPR_select, IR_in, MAR_in, MDR_in, MDR_out,
               RAM_enable_read, RAM_enable_write, Y_in, Y_out, Y_offset_in, Z_in, Z_out,
               halted, illegal_op, state
    );

endinterface

// File: rtl/control_decode.sv
// Moore decode of the sequencer state (plus latched opcode) into datapath strobes.
module control_decode
    import fpg8_pkg::*;
(
    input  state_e     state_i,
    input  logic [3:0] op_i,
    input  logic       s_i,
    input  logic       enable_i,
    output strobes_t   strobes_o
);

    // One state -> one strobe set; everything is dropped while disabled.
    always_comb begin
        strobes_o = '0;
        case (state_i)
            StF0: begin
                strobes_o.gpr_out     = 1'b1;
                strobes_o.gpr_select  = SelPc;
                strobes_o.mar_in      = 1'b1;
                strobes_o.alu_control = AluInc;
                strobes_o.z_in        = 1'b1;
            end
            StF1: begin
                strobes_o.ram_read   = 1'b1;
                strobes_o.z_out      = 1'b1;
                strobes_o.gpr_in     = 1'b1;
                strobes_o.gpr_select = SelPc;
            end
            StF2: begin
                strobes_o.mdr_out = 1'b1;
                strobes_o.ir_in   = 1'b1;
            end
            StE0: begin
                strobes_o.gpr_out     = 1'b1;
                strobes_o.gpr_select  = SelRs1;
                strobes_o.y_in        = 1'b1;
                strobes_o.y_offset_in = s_i;
            end
            StE1: begin
                strobes_o.gpr_out     = 1'b1;
                strobes_o.gpr_select  = is_unary(op_i) ? SelRs1 : SelRs2;
                strobes_o.alu_control = op_to_alu(op_i);
                strobes_o.z_in        = 1'b1;
            end
            StE2: begin
                strobes_o.z_out      = 1'b1;
                strobes_o.gpr_in     = 1'b1;
                strobes_o.gpr_select = SelRd1;
            end
            StM0: begin
                strobes_o.gpr_out    = 1'b1;
                strobes_o.gpr_select = SelRs1;
                strobes_o.mar_in     = 1'b1;
            end
            StM1: begin
                if (op_i == OpLd) begin
                    strobes_o.ram_read = 1'b1;
                end else begin
                    strobes_o.gpr_out    = 1'b1;
                    strobes_o.gpr_select = SelRs2;
                    strobes_o.mdr_in     = 1'b1;
                end
            end
            StM2: begin
                if (op_i == OpLd) begin
                    strobes_o.mdr_out    = 1'b1;
                    strobes_o.gpr_in     = 1'b1;
                    strobes_o.gpr_select = SelRd1;
                end else begin
                    strobes_o.ram_write = 1'b1;
                end
            end
            default: ;
        endcase
        if (!enable_i) begin
            strobes_o = '0;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// FPG8 hardwired sequencer: state register, decode-time branch latch and
// sticky status flags; strobes come from control_decode.
module control_sequencer
    import fpg8_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);

    state_e     state_q;
    logic [3:0] op_q;
    logic       s_q;
    logic       illegal_op_q;
    logic       halted_q;
    logic       strobe_enable;
    strobes_t   strobes;

    assign strobe_enable = bus.run & ~reset;

    // Step one micro-state per edge; DEC captures the IR fields so the execute
    // states never depend on the live IR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StF0;
            op_q         <= 4'd0;
            s_q          <= 1'b0;
            illegal_op_q <= 1'b0;
            halted_q     <= 1'b0;
        end else if (bus.run) begin
            case (state_q)
                StF0: state_q <= StF1;
                StF1: state_q <= StF2;
                StF2: state_q <= StDec;
                StDec: begin
                    op_q <= bus.opcode;
                    s_q  <= bus.S;
                    if (is_alu2(bus.opcode)) begin
                        state_q <= StE0;
                    end else if (is_unary(bus.opcode)) begin
                        state_q <= StE1;
                    end else if (is_mem(bus.opcode)) begin
                        state_q <= StM0;
                    end else if (bus.opcode == OpHalt) begin
                        state_q  <= StHlt;
                        halted_q <= 1'b1;
                    end else if (bus.opcode == OpNop) begin
                        state_q <= StF0;
                    end else begin
                        state_q      <= StF0;
                        illegal_op_q <= 1'b1;
                    end
                end
                StE0:    state_q <= StE1;
                StE1:    state_q <= StE2;
                StE2:    state_q <= StF0;
                StM0:    state_q <= StM1;
                StM1:    state_q <= StM2;
                StM2:    state_q <= StF0;
                StHlt:   state_q <= StHlt;
                default: state_q <= StF0;
            endcase
        end
    end

    control_decode u_decode (
        .state_i  (state_q),
        .op_i     (op_q),
        .s_i      (s_q),
        .enable_i (strobe_enable),
        .strobes_o(strobes)
    );

    assign bus.ALU_control      = strobes.alu_control;
    assign bus.GPR_in           = strobes.gpr_in;
    assign bus.GPR_out          = strobes.gpr_out;
    assign bus.GPR_select       = strobes.gpr_select;
    assign bus.IR_in            = strobes.ir_in;
    assign bus.MAR_in           = strobes.mar_in;
    assign bus.MDR_in           = strobes.mdr_in;
    assign bus.MDR_out          = strobes.mdr_out;
    assign bus.RAM_enable_read  = strobes.ram_read;
    assign bus.RAM_enable_write = strobes.ram_write;
    assign bus.Y_in             = strobes.y_in;
    assign bus.Y_out            = 1'b0;
    assign bus.Y_offset_in      = strobes.y_offset_in;
    assign bus.Z_in             = strobes.z_in;
    assign bus.Z_out            = strobes.z_out;
    assign bus.halted           = halted_q;
    assign bus.illegal_op       = illegal_op_q;
    assign bus.state            = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a behavioural FPG8 datapath driven by the DUT
// strobes, directed strobe-sequence tests and random programs checked against
// an instruction-level model.
// Instruction format used here: [15:12] op, [11] S, [10:8] rd, [7:5] rs1, [4:2] rs2.
module tb_control_sequencer;
    import fpg8_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;

    control_sequencer_if bus_if ();

    control_sequencer dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural datapath ----------------
    logic [15:0] r [8];
    logic [15:0] ram [256];
    logic [15:0] init_r [8];
    logic [15:0] init_ram [256];
    logic [15:0] ir, mar, mdr, y, z, dbus;
    logic        do_load = 1'b0;
    int          wr_count = 0;

    function automatic logic [2:0] reg_idx(input logic [2:0] sel, input logic [15:0] instr);
        case (sel)
            3'd0, 3'd1: return instr[10:8];
            3'd2:       return instr[7:5];
            3'd3:       return instr[4:2];
            default:    return 3'd7;
        endcase
    endfunction

    function automatic logic [15:0] alu(input logic [2:0] c, input logic [15:0] a,
                                        input logic [15:0] b);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~b;
            3'd6:    return b;
            default: return b + 16'd1;
        endcase
    endfunction

    always_comb begin
        dbus = 16'h0;
        if (bus_if.GPR_out) dbus = r[reg_idx(bus_if.GPR_select, ir)];
        else if (bus_if.MDR_out) dbus = mdr;
        else if (bus_if.Z_out) dbus = z;
    end

    assign bus_if.opcode = ir[15:12];
    assign bus_if.S      = ir[11];

    always @(posedge clk) begin
        if (do_load) begin
            r        <= init_r;
            ram      <= init_ram;
            ir       <= 16'h0;
            mar      <= 16'h0;
            mdr      <= 16'h0;
            y        <= 16'h0;
            z        <= 16'h0;
            wr_count <= 0;
        end else begin
            if (bus_if.GPR_in) r[reg_idx(bus_if.GPR_select, ir)] <= dbus;
            if (bus_if.IR_in) ir <= dbus;
            if (bus_if.MAR_in) mar <= dbus;
            if (bus_if.MDR_in) mdr <= dbus;
            if (bus_if.RAM_enable_read) mdr <= ram[mar[7:0]];
            if (bus_if.RAM_enable_write) begin
                ram[mar[7:0]] <= mdr;
                wr_count      <= wr_count + 1;
            end
            if (bus_if.Y_in) y <= dbus;
            if (bus_if.Z_in) z <= alu(bus_if.ALU_control, y, dbus);
        end
    end

    // {GPR_in, GPR_out, IR_in, MAR_in, MDR_in, MDR_out, RD, WR, Y_in, Y_offset, Z_in, Z_out}
    logic [11:0] strb;
    assign strb = {bus_if.GPR_in, bus_if.GPR_out, bus_if.IR_in, bus_if.MAR_in,
                   bus_if.MDR_in, bus_if.MDR_out, bus_if.RAM_enable_read,
                   bus_if.RAM_enable_write, bus_if.Y_in, bus_if.Y_offset_in,
                   bus_if.Z_in, bus_if.Z_out};

    localparam logic [11:0] VF0   = 12'b0101_0000_0010;
    localparam logic [11:0] VF1   = 12'b1000_0010_0001;
    localparam logic [11:0] VF2   = 12'b0010_0100_0000;
    localparam logic [11:0] VDEC  = 12'b0000_0000_0000;
    localparam logic [11:0] VE0   = 12'b0100_0000_1000;
    localparam logic [11:0] VE0S  = 12'b0100_0000_1100;
    localparam logic [11:0] VE1   = 12'b0100_0000_0010;
    localparam logic [11:0] VE2   = 12'b1000_0000_0001;
    localparam logic [11:0] VM0   = 12'b0101_0000_0000;
    localparam logic [11:0] VM1LD = 12'b0000_0010_0000;
    localparam logic [11:0] VM1ST = 12'b0100_1000_0000;
    localparam logic [11:0] VM2LD = 12'b1000_0100_0000;
    localparam logic [11:0] VM2ST = 12'b0000_0001_0000;

    // Bus-driver and Y_out invariants, every cycle once reset has been applied.
    logic mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("one_driver",
                     32'(int'(bus_if.GPR_out) + int'(bus_if.MDR_out) + int'(bus_if.Z_out) <= 1),
                     32'd1);
            check_eq("y_out_zero", bus_if.Y_out, 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] enc(input int op, input int s, input int rd, input int rs1,
                                        input int rs2);
        return {op[3:0], s[0], rd[2:0], rs1[2:0], rs2[2:0], 2'b00};
    endfunction

    task automatic clear_init();
        for (int i = 0; i < 8; i++) init_r[i] = 16'h0;
        for (int i = 0; i < 256; i++) init_ram[i] = 16'h0;
    endtask

    task automatic preload();
        @(negedge clk);
        do_load = 1'b1;
        @(posedge clk);
        #1 do_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Reset with run high: strobes must still be quiet during the reset cycle.
    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        bus_if.run  = 1'b1;
        #1;
        if (mon_en) check_eq("reset_strobes", strb, 12'h0);
        @(posedge clk);
        @(negedge clk);
        reset      = 1'b0;
        bus_if.run = 1'b0;
        mon_en     = 1'b1;
        #1;
        check_eq("reset_state", bus_if.state, StF0);
        check_eq("reset_halted", bus_if.halted, 32'd0);
        check_eq("reset_illegal", bus_if.illegal_op, 32'd0);
    endtask

    task automatic step(input string tag, input logic [11:0] vec, input int sel, input int aluc);
        #1;
        check_eq({tag, "_strobes"}, strb, vec);
        if (sel >= 0) check_eq({tag, "_sel"}, bus_if.GPR_select, sel);
        if (aluc >= 0) check_eq({tag, "_alu"}, bus_if.ALU_control, aluc);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch_steps();
        step("f0", VF0, int'(SelPc), int'(AluInc));
        step("f1", VF1, int'(SelPc), -1);
        step("f2", VF2, -1, -1);
        step("dec", VDEC, -1, -1);
    endtask

    // ---------------- instruction-level reference model ----------------
    logic [15:0] m_r [8];
    logic [15:0] m_mem [256];
    logic        m_ill, m_halt;
    int          m_cycles;

    task automatic run_model(input int max_instr);
        logic [15:0] instr;
        logic [3:0]  op;
        int          rd, rs1, rs2;
        m_r      = init_r;
        m_mem    = init_ram;
        m_ill    = 1'b0;
        m_halt   = 1'b0;
        m_cycles = 0;
        for (int n = 0; n < max_instr && !m_halt; n++) begin
            instr  = m_mem[m_r[7][7:0]];
            m_r[7] = m_r[7] + 16'd1;
            op  = instr[15:12];
            rd  = int'(instr[10:8]);
            rs1 = int'(instr[7:5]);
            rs2 = int'(instr[4:2]);
            case (op)
                4'd1: begin m_r[rd] = m_r[rs1] + m_r[rs2]; m_cycles += 7; end
                4'd2: begin m_r[rd] = m_r[rs1] - m_r[rs2]; m_cycles += 7; end
                4'd3: begin m_r[rd] = m_r[rs1] & m_r[rs2]; m_cycles += 7; end
                4'd4: begin m_r[rd] = m_r[rs1] | m_r[rs2]; m_cycles += 7; end
                4'd5: begin m_r[rd] = m_r[rs1] ^ m_r[rs2]; m_cycles += 7; end
                4'd6: begin m_r[rd] = ~m_r[rs1]; m_cycles += 6; end
                4'd7: begin m_r[rd] = m_r[rs1]; m_cycles += 6; end
                4'd8: begin m_r[rd] = m_mem[m_r[rs1][7:0]]; m_cycles += 7; end
                4'd9: begin m_mem[m_r[rs1][7:0]] = m_r[rs2]; m_cycles += 7; end
                4'd15: begin m_halt = 1'b1; m_cycles += 4; end
                4'd0: m_cycles += 4;
                default: begin m_ill = 1'b1; m_cycles += 4; end
            endcase
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int bad;
        int v;
        bus_if.run = 1'b0;
        run_cycles(2);

        // ADD R1 <- R2 + R3, full strobe sequence
        clear_init();
        init_r[2] = 16'd5;
        init_r[3] = 16'd7;
        init_ram[0] = enc(1, 0, 1, 2, 3);
        preload();
        do_reset();
        bus_if.run = 1'b1;
        fetch_steps();
        step("e0", VE0, int'(SelRs1), -1);
        step("e1", VE1, int'(SelRs2), int'(AluAdd));
        step("e2", VE2, int'(SelRd1), -1);
        bus_if.run = 1'b0;
        #1;
        check_eq("add_r1", r[1], 16'd12);
        check_eq("add_pc", r[7], 16'd1);
        check_eq("add_next_f0", bus_if.state, StF0);

        // LD R4 <- [R5], then ST [R5] <- R6
        clear_init();
        init_r[5] = 16'h0020;
        init_r[6] = 16'h1234;
        init_ram[8'h20] = 16'hBEEF;
        init_ram[0] = enc(8, 0, 4, 5, 0);
        init_ram[1] = enc(9, 0, 0, 5, 6);
        preload();
        do_reset();
        bus_if.run = 1'b1;
        run_cycles(4);
        step("ld_m0", VM0, int'(SelRs1), -1);
        step("ld_m1", VM1LD, -1, -1);
        step("ld_m2", VM2LD, int'(SelRd1), -1);
        check_eq("ld_r4", r[4], 16'hBEEF);
        run_cycles(4);
        step("st_m0", VM0, int'(SelRs1), -1);
        step("st_m1", VM1ST, int'(SelRs2), -1);
        step("st_m2", VM2ST, -1, -1);
        bus_if.run = 1'b0;
        #1;
        check_eq("st_ram", ram[8'h20], 16'h1234);
        check_eq("st_one_write", wr_count, 32'd1);
        check_eq("ldst_pc", r[7], 16'd2);

        // Illegal opcode 12, then NOP and MOV; flag is sticky
        clear_init();
        init_r[1] = 16'h5555;
        init_r[3] = 16'h0ABC;
        init_ram[0] = enc(12, 0, 1, 2, 3);
        init_ram[1] = enc(0, 0, 0, 0, 0);
        init_ram[2] = enc(7, 0, 2, 3, 0);
        preload();
        do_reset();
        bus_if.run = 1'b1;
        run_cycles(4);
        #1;
        check_eq("ill_flag", bus_if.illegal_op, 32'd1);
        check_eq("ill_state", bus_if.state, StF0);
        check_eq("ill_no_write", r[1], 16'h5555);
        check_eq("ill_pc", r[7], 16'd1);
        run_cycles(10);
        #1;
        check_eq("ill_sticky", bus_if.illegal_op, 32'd1);
        check_eq("mov_r2", r[2], 16'h0ABC);
        check_eq("mov_pc", r[7], 16'd3);
        bus_if.run = 1'b0;

        // HALT holds with no strobes until reset
        clear_init();
        init_ram[0] = 16'hF000;
        preload();
        do_reset();
        bus_if.run = 1'b1;
        run_cycles(4);
        for (int i = 0; i < 20; i++) begin
            #1;
            check_eq("hlt_halted", bus_if.halted, 32'd1);
            check_eq("hlt_strobes", strb, 12'h0);
            check_eq("hlt_state", bus_if.state, StHlt);
            run_cycles(1);
        end
        check_eq("hlt_pc", r[7], 16'd1);
        do_reset();

        // run=0 while in E1; resume reissues E1 (S=1 exercises Y_offset_in)
        clear_init();
        init_r[2] = 16'h0100;
        init_r[3] = 16'h0023;
        init_ram[0] = enc(1, 1, 1, 2, 3);
        preload();
        do_reset();
        bus_if.run = 1'b1;
        run_cycles(4);
        step("pe0", VE0S, int'(SelRs1), -1);
        bus_if.run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("pause_strobes", strb, 12'h0);
            check_eq("pause_state", bus_if.state, StE1);
            run_cycles(1);
        end
        bus_if.run = 1'b1;
        step("pe1", VE1, int'(SelRs2), int'(AluAdd));
        step("pe2", VE2, int'(SelRd1), -1);
        bus_if.run = 1'b0;
        #1;
        check_eq("pause_r1", r[1], 16'h0123);

        // Reset in M1 of ST: no write, registers untouched
        clear_init();
        init_r[5] = 16'h0030;
        init_r[6] = 16'h7777;
        init_ram[8'h30] = 16'hAAAA;
        init_ram[0] = enc(9, 0, 0, 5, 6);
        preload();
        do_reset();
        bus_if.run = 1'b1;
        run_cycles(5);
        #1;
        check_eq("m1_reached", bus_if.state, StM1);
        reset = 1'b1;
        #1;
        check_eq("m1_reset_strobes", strb, 12'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus_if.run = 1'b0;
        #1;
        check_eq("m1_reset_state", bus_if.state, StF0);
        check_eq("m1_no_write", ram[8'h30], 16'hAAAA);
        check_eq("m1_wr_count", wr_count, 32'd0);
        check_eq("m1_pc", r[7], 16'd1);
        check_eq("m1_r5", r[5], 16'h0030);
        check_eq("m1_r6", r[6], 16'h7777);

        // Random programs against the instruction-level model
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 7; i++) init_r[i] = 16'($urandom);
            init_r[7] = 16'h0;
            for (int i = 0; i < 256; i++) init_ram[i] = 16'($urandom);
            for (int i = 0; i < 20; i++) begin
                v = int'($urandom_range(0, 10));
                if (v == 10) v = int'($urandom_range(10, 14));
                init_ram[i] = enc(v, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                  int'($urandom_range(0, 7)));
            end
            run_model(16);
            preload();
            do_reset();
            bus_if.run = 1'b1;
            run_cycles(m_cycles);
            bus_if.run = 1'b0;
            #1;
            for (int i = 0; i < 8; i++) check_eq($sformatf("rnd%0d_r%0d", p, i), r[i], m_r[i]);
            bad = 0;
            for (int i = 0; i < 256; i++) if (ram[i] !== m_mem[i]) bad++;
            check_eq($sformatf("rnd%0d_ram_diffs", p), bad, 32'd0);
            check_eq($sformatf("rnd%0d_halted", p), bus_if.halted, m_halt);
            check_eq($sformatf("rnd%0d_illegal", p), bus_if.illegal_op, m_ill);
            check_eq($sformatf("rnd%0d_state", p), bus_if.state, m_halt ? StHlt : StF0);
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired fetch/decode/execute sequencer for the FPG8 16-bit single-bus datapath. It drives every datapath control strobe: GPR, IR, MAR, MDR, RAM, Y, Z and the ALU. It steps one micro-state per `clk` edge, using the one-shot clock in the top level. GPR R7 serves as the program counter. Replaces the manual debug latch as the bus master while running.

## Interface
- No parameters; all encodings come from the package.
- `clk` in 1: datapath clock (top-level one-shot clock).
- `reset` in 1: synchronous, active-high.
- `run` in 1: advance enable. Top level ties it low while `latch` drives the bus.
- `opcode` in 4: from IR. `S` in 1: from IR, requests Y shift/offset.
- `ALU_control` out 3; `GPR_in`, `GPR_out` out 1; `GPR_select` out 3.
- `IR_in`, `MAR_in`, `MDR_in`, `MDR_out` out 1.
- `RAM_enable_read`, `RAM_enable_write` out 1.
- `Y_in`, `Y_out`, `Y_offset_in`, `Z_in`, `Z_out` out 1.
- `halted` out 1; `illegal_op` out 1 (sticky); `state` out 4 (debug).

## Operation
- Encodings:
  - GPR_select: 0=Rd_1, 1=Rd_2, 2=Rs_1, 3=Rs_2, 4=R7(PC).
  - ALU_control: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 PASS, 7 INC.
  - Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 MOV, 8 LD, 9 ST, 15 HALT. Codes 10–14 are illegal.
- States and strobes:
  - F0: GPR_out, sel=PC, MAR_in, ALU=INC, Z_in.
  - F1: RAM_enable_read, Z_out, GPR_in, sel=PC.
  - F2: MDR_out, IR_in.
  - DEC: no strobes; the IR fields settle here. Next state: ADD..XOR→E0; NOT/MOV→E1; LD/ST→M0; NOP→F0; HALT→HLT; illegal→F0 and set `illegal_op`.
  - E0: GPR_out sel=Rs_1, Y_in, Y_offset_in=S.
  - E1: GPR_out; sel=Rs_2 for two-operand ops, Rs_1 for NOT/MOV. ALU=op (PASS for MOV), Z_in.
  - E2: Z_out, GPR_in sel=Rd_1, then →F0.
  - M0: GPR_out sel=Rs_1, MAR_in.
  - M1 (LD): RAM_enable_read. M1 (ST): GPR_out sel=Rs_2, MDR_in.
  - M2 (LD): MDR_out, GPR_in sel=Rd_1. M2 (ST): RAM_enable_write. Both then →F0.
  - HLT: no strobes; `halted`=1; exits only on reset.
- Bus rule: at most one of GPR_out, MDR_out, Z_out per state. `Y_out` is permanently 0.
- `opcode` is sampled only in DEC. The branch decision is latched internally so M1/M2 do not depend on live IR.
- Strobes are a Moore decode of the registered state. When `run`=0 or `reset`=1, all strobes are forced to 0.

## Timing
- Reset:
  - state←F0, `illegal_op`←0, `halted`←0.
  - All strobes read 0 during the reset cycle.
  - The first F0 strobes appear in the first cycle with reset=0 and run=1.
- One state per `clk` edge while `run`=1. The datapath captures strobes on the edge that ends the state.
- `run`=0 freezes the state with all strobes 0. On resume, the frozen state's strobes are reissued in full.
- Instruction latency in cycles:
  - NOP and illegal: 4.
  - NOT, MOV: 6.
  - ALU, LD, ST: 7.
  - The next F0 follows immediately.
- Reset wins over `run` in every state, including mid-instruction and HLT. A partially executed ST whose M2 has not been reached performs no write.
- PC increments (mod 2^16) in F1 of every fetch, including the fetch of illegal and HALT opcodes.

## Structure
- Package `fpg8_pkg` holds the opcode, ALU_control, GPR_select and state enumerations, shared with the ALU, GPR and the top level.
- Sub-module `control_decode`: combinational state+op → strobe vector. It is instantiated once; this block keeps the state register, branch latch and flags.

## Test plan
- Reset, then run=1 with RAM[0]=ADD R1←R2+R3 (R2=5, R3=7) → strobe sequence F0,F1,F2,DEC,E0,E1,E2 matches the Operation list exactly; R1=12 and PC=1 after 7 cycles.
- LD R4←[R5] with R5=0x20 and RAM[0x20]=0xBEEF → R4=0xBEEF after 7 cycles. ST [R5]←R6 with R6=0x1234 → RAM[0x20]=0x1234, and `RAM_enable_write` is high for exactly 1 cycle.
- Opcode 12 → `illegal_op`=1 after DEC, next state F0, no GPR write. The flag stays set across later instructions until reset.
- HALT → `halted`=1 and all strobes 0 for 20 further cycles. Reset → state F0 and `halted`=0.
- run=0 in E1 for 5 cycles → strobes 0, state held at E1. On resume, E1 strobes reissue and the result is unchanged.
- Reset asserted in M1 of ST → no RAM write; PC and the other GPRs keep their current values; state F0 the next cycle.
- Every cycle of all runs: assertion that at most one bus driver is active and `Y_out`=0.
